machine_timer: RTL

MACHINE_TIMER -- requirements
Module: machine_timer

---
 rtl/machine_timer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/machine_timer.sv
// Memory-mapped 64-bit machine timer (mtime/mtimecmp) with a registered timer interrupt level.
// Optional tick prescaler compiled in with `define MACHINE_TIMER_PRESCALER_EN.

// state  | meaning
// S_IDLE | waiting for a selected request; the access is performed on the leaving edge
// S_ACK  | ack pulse cycle; rdata/fault hold the result, req is not sampled
module machine_timer #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
`ifdef MACHINE_TIMER_PRESCALER_EN
  , parameter int unsigned PRESCALE = 16
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        fault,
  output logic        sel,
  output logic        timer
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [63:0] mtime_q;
  logic [63:0] mtime_d;
  logic [63:0] cmp_q;
  logic [63:0] cmp_d;
  logic [31:0] shadow_q;
  logic [31:0] rdata_q;
  logic        fault_q;
  logic        timer_q;
  logic [31:0] rd_word;
  logic        access;
  logic        misalign;
  logic        wr_ok;
  logic        rd_ok;
  logic        wr_mtime_lo;
  logic        wr_mtime_hi;
  logic        wr_cmp_lo;
  logic        wr_cmp_hi;
  logic        tick;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  en);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = en[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return res;
  endfunction

  assign sel      = req && (addr[31:4] == BASE_ADDR[31:4]);
  assign access   = (state_q == S_IDLE) && sel;
  assign misalign = (addr[1:0] != 2'b00);
  assign wr_ok    = access && we && !misalign;
  assign rd_ok    = access && !we && !misalign;

  // A write with no enabled bytes leaves mtime alone, so the tick still counts.
  assign wr_mtime_lo = wr_ok && (addr[3:2] == 2'd0) && (be != 4'b0000);
  assign wr_mtime_hi = wr_ok && (addr[3:2] == 2'd1) && (be != 4'b0000);
  assign wr_cmp_lo   = wr_ok && (addr[3:2] == 2'd2);
  assign wr_cmp_hi   = wr_ok && (addr[3:2] == 2'd3);

`ifdef MACHINE_TIMER_PRESCALER_EN
  localparam logic [15:0] PRE_RELOAD = 16'(PRESCALE - 1);

  logic [15:0] pre_cnt;

  // Count 0 means "just reloaded": load PRESCALE-1, tick when it reaches 1.
  assign tick = (PRESCALE == 1) ? 1'b1 : (pre_cnt == 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= 16'd0;
    end else if (tick) begin
      pre_cnt <= 16'd0;
    end else if (pre_cnt == 16'd0) begin
      pre_cnt <= PRE_RELOAD;
    end else begin
      pre_cnt <= pre_cnt - 16'd1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (sel) state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ack   = (state_q == S_ACK);
    rdata = rdata_q;
    fault = fault_q;
    timer = timer_q;
  end

  // A software write to either half wins over the tick in that cycle.
  always_comb begin
    mtime_d = mtime_q;
    if (wr_mtime_lo) begin
      mtime_d[31:0] = merge_bytes(mtime_q[31:0], wdata, be);
    end else if (wr_mtime_hi) begin
      mtime_d[63:32] = merge_bytes(mtime_q[63:32], wdata, be);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_comb begin
    cmp_d = cmp_q;
    if (wr_cmp_lo) begin
      cmp_d[31:0] = merge_bytes(cmp_q[31:0], wdata, be);
    end
    if (wr_cmp_hi) begin
      cmp_d[63:32] = merge_bytes(cmp_q[63:32], wdata, be);
    end
  end

  always_comb begin
    rd_word = 32'd0;
    case (addr[3:2])
      2'd0:    rd_word = mtime_q[31:0];
      2'd1:    rd_word = shadow_q;
      2'd2:    rd_word = cmp_q[31:0];
      2'd3:    rd_word = cmp_q[63:32];
      default: rd_word = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_q  <= 64'd0;
      cmp_q    <= 64'hFFFF_FFFF_FFFF_FFFF;
      shadow_q <= 32'd0;
      rdata_q  <= 32'd0;
      fault_q  <= 1'b0;
      timer_q  <= 1'b0;
    end else begin
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      timer_q <= (mtime_q >= cmp_q);
      if (rd_ok && (addr[3:2] == 2'd0)) begin
        shadow_q <= mtime_q[63:32];
      end
      rdata_q <= rd_ok ? rd_word : 32'd0;
      fault_q <= access && misalign;
    end
  end

endmodule
